multicycle_control: RTL and testbench

//  Main control FSM of the multicycle RV32I core; sits directly upstream of the ALU.

---
 rtl/multicycle_control.sv | 229 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core.
// Sequences fetch..writeback and drives the ALU operand and opcode selects.
module multicycle_control #(
  parameter int WIDTH      = 32,
  parameter int WAIT_LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             comparison,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             addr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [6:0]       alu_opcode,
  output logic             instr_done,
  output logic [WIDTH-1:0] instret,
  output logic             trap,
  output logic             trap_cause
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXECUTE,
    S_ALU_WB,
    S_BRANCH,
    S_JALR,
    S_JUMP_LINK,
    S_TRAP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    wait_q, wait_d;
  logic [WIDTH-1:0] instret_q, instret_d;
  logic             trap_q, trap_d;
  logic             cause_q, cause_d;

  logic waiting;
  logic timeout;
  logic retire;
  logic mem_read_s, mem_write_s, ir_write_s;
  logic pc_write_s, reg_write_s;

  assign waiting = !mem_ready &&
                   (state_q == S_FETCH ||
                    state_q == S_MEM_READ ||
                    state_q == S_MEM_WRITE);

  assign timeout = waiting && (WAIT_LIMIT != 0) &&
                   (wait_q == CW'(WAIT_LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    instret_d   = instret_q;
    trap_d      = trap_q;
    cause_d     = cause_q;
    retire      = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    pc_write_s  = 1'b0;
    reg_write_s = 1'b0;
    addr_src    = 1'b0;
    pc_src      = 1'b0;
    result_src  = 2'd0;
    alu_src_a   = 2'd0;
    alu_src_b   = 2'd0;
    alu_opcode  = OP_AUIPC;

    if (waiting) wait_d = wait_q + CW'(1);

    unique case (state_q)
      S_FETCH: begin
        mem_read_s = 1'b1;
        alu_src_b  = 2'd2;
        if (mem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        // branch/jump target lands in alu_out
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        unique case (1'b1)
          opcode == OP_LOAD,
          opcode == OP_STORE:  state_d = S_MEM_ADDR;
          opcode == OP_IMM,
          opcode == OP_REG,
          opcode == OP_LUI:    state_d = S_EXECUTE;
          opcode == OP_AUIPC:  state_d = S_ALU_WB;
          opcode == OP_BRANCH: state_d = S_BRANCH;
          opcode == OP_JAL:    state_d = S_JUMP_LINK;
          opcode == OP_JALR:   state_d = S_JALR;
          default: begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
            cause_d = 1'b0;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a  = 2'd2;
        alu_src_b  = 2'd1;
        alu_opcode = opcode;
        state_d    = (opcode == OP_LOAD) ? S_MEM_READ
                                         : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read_s = 1'b1;
        addr_src   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_s = 1'b1;
        result_src  = 2'd1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write_s = 1'b1;
        addr_src    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alu_src_a  = 2'd2;
        alu_src_b  = (opcode == OP_REG) ? 2'd0 : 2'd1;
        alu_opcode = opcode;
        state_d    = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_s = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'd2;
        alu_opcode = OP_BRANCH;
        pc_write_s = comparison;
        pc_src     = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JALR: begin
        alu_src_a  = 2'd2;
        alu_src_b  = 2'd1;
        alu_opcode = OP_JALR;
        state_d    = S_JUMP_LINK;
      end
      S_JUMP_LINK: begin
        pc_write_s  = 1'b1;
        pc_src      = 1'b1;
        alu_src_a   = 2'd1;
        alu_src_b   = 2'd2;
        reg_write_s = 1'b1;
        result_src  = 2'd2;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // a late mem_ready in the limit cycle never reaches here
    if (timeout) begin
      state_d = S_TRAP;
      trap_d  = 1'b1;
      cause_d = 1'b1;
    end

    if (retire) instret_d = instret_q + WIDTH'(1);
  end

  assign mem_read   = mem_read_s  & ~rst;
  assign mem_write  = mem_write_s & ~rst;
  assign ir_write   = ir_write_s  & ~rst;
  assign pc_write   = pc_write_s  & ~rst;
  assign reg_write  = reg_write_s & ~rst;
  assign instr_done = retire      & ~rst;
  assign instret    = instret_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against a per-instruction
// phase-list model (narrow instret and short bus timeout).
module tb_multicycle_control;

  localparam int W   = 4;
  localparam int LIM = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [6:0]   opcode = '0;
  logic         comparison = 1'b0;
  logic         mem_ready = 1'b0;
  logic         mem_read, mem_write, addr_src, ir_write;
  logic         pc_write, pc_src, reg_write, instr_done;
  logic [1:0]   result_src, alu_src_a, alu_src_b;
  logic [6:0]   alu_opcode;
  logic [W-1:0] instret;
  logic         trap, trap_cause;

  always #5 clk = ~clk;

  multicycle_control #(.WIDTH(W), .WAIT_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .comparison(comparison), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .addr_src(addr_src), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_opcode(alu_opcode), .instr_done(instr_done),
    .instret(instret), .trap(trap), .trap_cause(trap_cause)
  );

  typedef enum {
    P_FETCH, P_DEC, P_MADDR, P_MRD, P_MWB, P_MWR,
    P_EXE, P_AWB, P_BR, P_JALR, P_JL, P_TRAP
  } ph_t;

  typedef struct packed {
    logic mr; logic mw; logic as; logic irw;
    logic pcw; logic pcs; logic rw;
    logic [1:0] rs; logic [1:0] sa; logic [1:0] sb;
    logic [6:0] aop; logic done; logic [W-1:0] ir;
    logic tr; logic tc;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   m_instret = 0;
  bit   m_trap = 0;
  bit   m_cause = 0;
  vec_t obs_q[$];
  vec_t exp_q[$];
  ph_t  ph_q[$];

  function automatic vec_t sample();
    vec_t s;
    s.mr = mem_read;   s.mw = mem_write;
    s.as = addr_src;   s.irw = ir_write;
    s.pcw = pc_write;  s.pcs = pc_src;
    s.rw = reg_write;  s.rs = result_src;
    s.sa = alu_src_a;  s.sb = alu_src_b;
    s.aop = alu_opcode; s.done = instr_done;
    s.ir = instret;    s.tr = trap;
    s.tc = trap_cause;
    return s;
  endfunction

  // what each phase of an instruction should present
  function automatic vec_t expect_of(ph_t p, logic [6:0] op,
                                     bit rdy, bit cmp);
    vec_t e;
    e = '0;
    e.aop = 7'b0010111;
    e.ir = W'(m_instret % (1 << W));
    e.tr = m_trap;
    e.tc = m_cause;
    case (p)
      P_FETCH: begin
        e.mr = 1; e.sb = 2; e.irw = rdy; e.pcw = rdy;
      end
      P_DEC:   begin e.sa = 1; e.sb = 1; end
      P_MADDR: begin e.sa = 2; e.sb = 1; e.aop = op; end
      P_MRD:   begin e.mr = 1; e.as = 1; end
      P_MWB:   begin e.rw = 1; e.rs = 1; e.done = 1; end
      P_MWR:   begin e.mw = 1; e.as = 1; e.done = rdy; end
      P_EXE: begin
        e.sa = 2; e.aop = op;
        e.sb = (op == 7'b0110011) ? 2'd0 : 2'd1;
      end
      P_AWB:  begin e.rw = 1; e.done = 1; end
      P_BR: begin
        e.sa = 2; e.sb = 0; e.aop = 7'b1100011;
        e.pcw = cmp; e.pcs = 1; e.done = 1;
      end
      P_JALR: begin e.sa = 2; e.sb = 1; e.aop = 7'b1100111; end
      P_JL: begin
        e.pcw = 1; e.pcs = 1; e.sa = 1; e.sb = 2;
        e.rw = 1; e.rs = 2; e.done = 1;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic cycle(input ph_t p, input logic [6:0] op,
                       input bit rdy, input bit cmp);
    vec_t e;
    @(negedge clk);
    opcode = (p == P_FETCH) ? 7'($urandom) : op;
    mem_ready = rdy;
    comparison = cmp;
    #1;
    e = expect_of(p, op, rdy, cmp);
    obs_q.push_back(sample());
    exp_q.push_back(e);
    ph_q.push_back(p);
    if (e.done) m_instret = m_instret + 1;
  endtask

  task automatic run_instr(input logic [6:0] op, input bit cmp,
                           input int fdly, input int mdly);
    ph_t seq[$];
    obs_q.delete(); exp_q.delete(); ph_q.delete();
    seq.push_back(P_FETCH);
    seq.push_back(P_DEC);
    case (op)
      7'b0000011: begin
        seq.push_back(P_MADDR); seq.push_back(P_MRD);
        seq.push_back(P_MWB);
      end
      7'b0100011: begin
        seq.push_back(P_MADDR); seq.push_back(P_MWR);
      end
      7'b0010011, 7'b0110011, 7'b0110111: begin
        seq.push_back(P_EXE); seq.push_back(P_AWB);
      end
      7'b0010111: seq.push_back(P_AWB);
      7'b1100011: seq.push_back(P_BR);
      7'b1101111: seq.push_back(P_JL);
      7'b1100111: begin
        seq.push_back(P_JALR); seq.push_back(P_JL);
      end
      default: seq.push_back(P_TRAP);
    endcase
    for (int k = 0; k < seq.size(); k++) begin
      ph_t p;
      int  d;
      p = seq[k];
      d = (p == P_FETCH) ? fdly : mdly;
      if (p == P_TRAP) begin
        m_trap = 1; m_cause = 0;
        repeat (3) cycle(P_TRAP, op, 1'($urandom), 1'($urandom));
        break;
      end
      if (p inside {P_FETCH, P_MRD, P_MWR}) begin
        for (int i = 0; i < d && i < LIM; i++)
          cycle(p, op, 1'b0, 1'($urandom));
        if (d >= LIM) begin
          m_trap = 1; m_cause = 1;
          repeat (3) cycle(P_TRAP, op, 1'($urandom), 1'($urandom));
          break;
        end
        cycle(p, op, 1'b1, 1'($urandom));
      end else begin
        cycle(p, op, 1'($urandom),
              (p == P_BR) ? cmp : 1'($urandom));
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; mem_ready = 0;
    @(posedge clk);
    #1 rst = 0;
    m_instret = 0; m_trap = 0; m_cause = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; mem_ready = 1;
    #1;
    tests++;
    if ({mem_read, mem_write, ir_write, pc_write,
         reg_write, instr_done} !== 6'b0) begin
      fails++;
      $display("FAIL reset_strobes got %b want 000000",
               {mem_read, mem_write, ir_write, pc_write,
                reg_write, instr_done});
    end
    tests++;
    if (instret !== '0) begin
      fails++;
      $display("FAIL reset_instret got %0d want 0", instret);
    end
    tests++;
    if ({trap, trap_cause} !== 2'b00) begin
      fails++;
      $display("FAIL reset_trap got %b want 00", {trap, trap_cause});
    end
    @(posedge clk);
    #1 rst = 0;
    m_instret = 0; m_trap = 0; m_cause = 0;
  endtask

  task automatic test_addi();
    int ndone;
    ndone = 0;
    run_instr(7'b0010011, 1'b0, 0, 0);
    foreach (obs_q[i]) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL addi %s c%0d got %h want %h",
                 ph_q[i].name(), i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].done) ndone++;
    end
    tests++;
    if (obs_q.size() != 4 || ndone != 1) begin
      fails++;
      $display("FAIL addi_len got %0d cyc %0d done want 4 1",
               obs_q.size(), ndone);
    end
    @(posedge clk);
    #1;
    tests++;
    if (instret !== W'(1)) begin
      fails++;
      $display("FAIL addi_instret got %0d want 1", instret);
    end
  endtask

  task automatic test_lw_wait();
    int nrd;
    nrd = 0;
    run_instr(7'b0000011, 1'b0, 0, 3);
    foreach (obs_q[i]) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL lw %s c%0d got %h want %h",
                 ph_q[i].name(), i, obs_q[i], exp_q[i]);
      end
      if (ph_q[i] == P_MRD && obs_q[i].mr) nrd++;
    end
    tests++;
    if (nrd != 4) begin
      fails++;
      $display("FAIL lw_hold got %0d want 4", nrd);
    end
  endtask

  task automatic test_beq();
    for (int c = 1; c >= 0; c--) begin
      run_instr(7'b1100011, 1'(c), 0, 0);
      foreach (obs_q[i]) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL beq%0d %s c%0d got %h want %h", c,
                   ph_q[i].name(), i, obs_q[i], exp_q[i]);
        end
      end
      tests++;
      if (obs_q.size() != 3 || obs_q[2].pcw !== 1'(c) ||
          obs_q[2].pcs !== 1'b1 || obs_q[2].done !== 1'b1) begin
        fails++;
        $display("FAIL beq%0d_br got len %0d pcw %b pcs %b want 3 %0d 1",
                 c, obs_q.size(), obs_q[2].pcw, obs_q[2].pcs, c);
      end
    end
  endtask

  task automatic test_jalr();
    run_instr(7'b1100111, 1'b0, 1, 0);
    foreach (obs_q[i]) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL jalr %s c%0d got %h want %h",
                 ph_q[i].name(), i, obs_q[i], exp_q[i]);
      end
    end
    tests++;
    if (obs_q[3].aop !== 7'b1100111 || obs_q[3].sa !== 2'd2 ||
        obs_q[3].sb !== 2'd1) begin
      fails++;
      $display("FAIL jalr_ops got %b %0d %0d want 1100111 2 1",
               obs_q[3].aop, obs_q[3].sa, obs_q[3].sb);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [9];
    ops = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011,
            7'b0110111, 7'b0010111, 7'b1100011, 7'b1101111,
            7'b1100111};
    for (int n = 0; n < 80; n++) begin
      run_instr(ops[$urandom_range(0, 8)], 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3));
      foreach (obs_q[i]) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL rand%0d %s c%0d got %h want %h", n,
                   ph_q[i].name(), i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_rst_midwrite();
    run_instr(7'b0100011, 1'b0, 0, 0);
    foreach (obs_q[i]) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL sw %s c%0d got %h want %h",
                 ph_q[i].name(), i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete(); ph_q.delete();
    cycle(P_FETCH, 7'b0100011, 1'b1, 1'b0);
    cycle(P_DEC, 7'b0100011, 1'b0, 1'b0);
    cycle(P_MADDR, 7'b0100011, 1'b0, 1'b0);
    cycle(P_MWR, 7'b0100011, 1'b0, 1'b0);
    foreach (obs_q[i]) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL swpart %s c%0d got %h want %h",
                 ph_q[i].name(), i, obs_q[i], exp_q[i]);
      end
    end
    @(negedge clk);
    mem_ready = 1;
    rst = 1;
    #1;
    tests++;
    if (mem_write !== 1'b0 || instr_done !== 1'b0) begin
      fails++;
      $display("FAIL rst_mw got mw %b done %b want 0 0",
               mem_write, instr_done);
    end
    @(posedge clk);
    #1 rst = 0;
    m_instret = 0;
    @(negedge clk);
    mem_ready = 0;
    #1;
    tests++;
    if (mem_read !== 1'b1 || alu_src_b !== 2'd2 ||
        instret !== '0 || instr_done !== 1'b0) begin
      fails++;
      $display("FAIL rst_fetch got mr %b sb %0d ir %0d want 1 2 0",
               mem_read, alu_src_b, instret);
    end
    do_reset();
  endtask

  task automatic test_illegal();
    run_instr(7'b1111111, 1'b0, 0, 0);
    foreach (obs_q[i]) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL illegal %s c%0d got %h want %h",
                 ph_q[i].name(), i, obs_q[i], exp_q[i]);
      end
    end
    tests++;
    if (trap !== 1'b1 || trap_cause !== 1'b0) begin
      fails++;
      $display("FAIL illegal_cause got %b%b want 10", trap, trap_cause);
    end
    do_reset();
  endtask

  task automatic test_timeout();
    run_instr(7'b0010011, 1'b0, 3, 0);
    foreach (obs_q[i]) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL edge_ok %s c%0d got %h want %h",
                 ph_q[i].name(), i, obs_q[i], exp_q[i]);
      end
    end
    run_instr(7'b0010011, 1'b0, 4, 0);
    foreach (obs_q[i]) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL to_fetch %s c%0d got %h want %h",
                 ph_q[i].name(), i, obs_q[i], exp_q[i]);
      end
    end
    tests++;
    if (trap !== 1'b1 || trap_cause !== 1'b1) begin
      fails++;
      $display("FAIL to_cause got %b%b want 11", trap, trap_cause);
    end
    do_reset();
    run_instr(7'b0000011, 1'b0, 0, 4);
    foreach (obs_q[i]) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL to_mrd %s c%0d got %h want %h",
                 ph_q[i].name(), i, obs_q[i], exp_q[i]);
      end
    end
    do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addi();
    test_lw_wait();
    test_beq();
    test_jalr();
    test_random();
    test_rst_midwrite();
    test_illegal();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
